ln_unit: RTL

- Fixed-point natural-log unit; the inverse of the datapath's exp block.
- Converts a positive Q.8 operand (8 fractional bits) to ln(x) in signed Q.8.
- Uses iterative one-bit-per-cycle range normalisation, then a two-stage quadratic mantissa correction.
- Sits in the softmax normalisation / log-softmax path behind a valid/ready handshake on both sides.

---
 rtl/ln_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ln_unit.sv
// Fixed-point natural log: positive Q.8 operand in, signed Q.8 ln(x) out.
// Range-normalises one bit per cycle, then applies a quadratic mantissa correction.
module ln_unit #(
  parameter int DW  = 32,
  parameter int LN2 = 177,
  parameter int C2  = 79
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] y,
  output logic          err
);

  localparam int KW = $clog2(DW) + 1;
  localparam logic signed [DW-1:0] LN2_C = DW'(LN2);
  localparam logic [23:0]          C2_C  = 24'(C2);

  typedef enum logic [2:0] {IDLE, NORM, SQ, SUM, DONE} state_t;

  state_t                state, state_nx;
  logic [DW-1:0]         m, m_nx;
  logic signed [KW-1:0]  k, k_nx;
  logic [7:0]            f, f_nx;
  logic [15:0]           sq, sq_nx;
  logic [DW-1:0]         y_r, y_nx;
  logic                  err_r, err_nx;

  logic signed [DW-1:0]  k_ext;
  logic signed [DW-1:0]  k_term;
  logic [23:0]           prod;
  logic [23:0]           corr;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // Input side is ready only in IDLE; output holds y/err with out_valid high
  // in DONE until out_ready, so jobs never overlap.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign y         = y_r;
  assign err       = err_r;

  assign k_ext  = {{(DW-KW){k[KW-1]}}, k};
  assign k_term = k_ext * LN2_C;
  assign prod   = C2_C * {8'd0, sq};
  assign corr   = prod >> 16;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m     <= '0;
      k     <= '0;
      f     <= '0;
      sq    <= '0;
      y_r   <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_nx;
      m     <= m_nx;
      k     <= k_nx;
      f     <= f_nx;
      sq    <= sq_nx;
      y_r   <= y_nx;
      err_r <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    m_nx     = m;
    k_nx     = k;
    f_nx     = f;
    sq_nx    = sq;
    y_nx     = y_r;
    err_nx   = err_r;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (x[DW-1] || (x == '0)) begin
            err_nx   = 1'b1;
            y_nx     = {1'b1, {(DW-1){1'b0}}};
            state_nx = DONE;
          end else begin
            m_nx     = x;
            k_nx     = '0;
            state_nx = NORM;
          end
        end
      end
      NORM: begin
        if (m >= DW'(512)) begin
          m_nx = m >> 1;
          k_nx = k + KW'(1);
        end else if (m < DW'(256)) begin
          m_nx = m << 1;
          k_nx = k - KW'(1);
        end else begin
          // m is in [256,511], so the fraction is just the low byte
          f_nx     = m[7:0];
          state_nx = SQ;
        end
      end
      SQ: begin
        sq_nx    = {8'd0, f} * {8'd0, f};
        state_nx = SUM;
      end
      SUM: begin
        y_nx     = k_term + {{(DW-8){1'b0}}, f} - {{(DW-24){1'b0}}, corr};
        err_nx   = 1'b0;
        state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
